// File: rtl/dmem_result_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_result_reader: streams a word range of data memory with a checksum  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module dmem_result_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_OUTPUT  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_ptr;
  logic [ADDR_W:0]   remaining;

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = (count == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_rd_en = 1'b1;
        mem_addr  = addr_ptr;
        state_nxt = S_CAPTURE;
      end
      S_CAPTURE: state_nxt = S_OUTPUT;
      S_OUTPUT: begin
        if (out_ready) begin
          state_nxt = (remaining == (ADDR_W+1)'(1)) ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      addr_ptr  <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      checksum  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_ptr  <= base_addr;
            remaining <= count;
            checksum  <= '0;
          end
        end
        // Read data is only valid here, one cycle after the strobe in ISSUE.
        S_CAPTURE: begin
          out_data  <= mem_rd_data;
          out_addr  <= addr_ptr;
          out_valid <= 1'b1;
        end
        S_OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            checksum  <= checksum + out_data;
            addr_ptr  <= addr_ptr + ADDR_W'(1);
            remaining <= remaining - (ADDR_W+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
